// File: rtl/pp_acc_pkg.sv
// Shared constants, FSM state type and beat lane extraction for the
// partial-product accumulator.
package pp_acc_pkg;

   localparam int unsigned DEPTH  = 784;
   localparam int unsigned COEF_W = 18;
   localparam int unsigned IDX_W  = 11;
   localparam int unsigned IDXC_W = 10;
   localparam int unsigned BEATS  = (DEPTH / 2) * (DEPTH / 2);

   typedef enum logic [1:0] {
      ST_CLEAR  = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_OUTPUT = 2'd3
   } acc_state_e;

   // Lane k of a beat occupies bits [k*COEF_W +: COEF_W].
   function automatic logic [COEF_W-1:0] lane_of(input logic [3*COEF_W-1:0] beat,
                                                  input logic [1:0]          lane);
      return beat[32'(lane)*COEF_W +: COEF_W];
   endfunction

endpackage

// File: rtl/coef_ram.sv
// Simple dual-port coefficient RAM: 1-cycle synchronous read, read-first
// on a same-address collision, no reset on contents or read data.
module coef_ram #(
   parameter int unsigned DEPTH_P = 784,
   parameter int unsigned W       = 18,
   localparam int unsigned AW     = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1
) (
   input  logic          clk_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [W-1:0]  rd_data_o,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_data_i
);

   logic [W-1:0] mem_q [DEPTH_P];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_o <= mem_q[rd_addr_i];
      end
   end

endmodule

// File: rtl/pp_accumulator.sv
// Accumulates 3-lane partial-product beats into a negacyclic (mod x^DEPTH+1)
// coefficient buffer, then streams the result out with clear-on-read.
module pp_accumulator
   import pp_acc_pkg::*;
#(
   parameter int unsigned DEPTH_P = DEPTH,
   parameter int unsigned BEATS_P = BEATS
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                B_valid,
   output logic                B_ready,
   input  logic [IDX_W-1:0]    idx_B,
   input  logic [3*COEF_W-1:0] B_in,
   output logic                C_valid,
   input  logic                C_ready,
   output logic [IDXC_W-1:0]   idx_C,
   output logic [COEF_W-1:0]   C_out,
   output logic                err_idx
);

   localparam int unsigned AW    = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
   localparam int unsigned CNT_W = $clog2(BEATS_P + 1);
   localparam int unsigned P_W   = IDX_W + 1;
   localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH_P - 1);
   localparam logic [P_W-1:0]   MAX_IDX   = P_W'(2 * DEPTH_P - 3);
   localparam logic [P_W-1:0]   DEPTH_W   = P_W'(DEPTH_P);
   localparam logic [CNT_W-1:0] BEATS_W   = CNT_W'(BEATS_P);

   acc_state_e           state_q;
   logic [AW-1:0]        ptr_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 b_ready_q;
   logic                 c_valid_q;
   logic [IDXC_W-1:0]    idx_c_q;
   logic                 err_q;

   logic                 busy_q;
   logic [1:0]           lane_q;
   logic [3*COEF_W-1:0]  beat_q;
   logic [IDX_W-1:0]     base_q;
   logic                 bad_q;

   logic                 s1_valid_q;
   logic [AW-1:0]        s1_addr_q;
   logic                 s1_neg_q;
   logic [COEF_W-1:0]    s1_lane_q;
   logic                 s1_hit_q;
   logic [COEF_W-1:0]    s1_fwd_q;

   logic                 accept_c;
   logic                 bad_c;
   logic                 lane_rd_c;
   logic [P_W-1:0]       p_c;
   logic                 lane_neg_c;
   logic [AW-1:0]        lane_addr_c;
   logic [COEF_W-1:0]    lane_val_c;
   logic [COEF_W-1:0]    operand_c;
   logic [COEF_W-1:0]    acc_c;
   logic                 rd_en_c;
   logic [AW-1:0]        rd_addr_c;
   logic [COEF_W-1:0]    rd_data_c;
   logic                 wr_en_c;
   logic [AW-1:0]        wr_addr_c;
   logic [COEF_W-1:0]    wr_data_c;

   assign accept_c  = B_valid && b_ready_q;
   assign bad_c     = P_W'(idx_B) > MAX_IDX;
   assign lane_rd_c = busy_q && !bad_q;

   // Negacyclic fold of the current lane and the read-modify-write datapath.
   always_comb begin
      p_c         = P_W'(base_q) + P_W'(lane_q);
      lane_neg_c  = (p_c >= DEPTH_W);
      lane_addr_c = lane_neg_c ? AW'(p_c - DEPTH_W) : AW'(p_c);
      lane_val_c  = lane_of(beat_q, lane_q);
      operand_c   = s1_hit_q ? s1_fwd_q : rd_data_c;
      acc_c       = s1_neg_q ? (operand_c - s1_lane_q) : (operand_c + s1_lane_q);
   end

   // RAM port arbitration; phases never overlap, so state alone selects the owner.
   always_comb begin
      rd_en_c   = 1'b0;
      rd_addr_c = '0;
      wr_en_c   = 1'b0;
      wr_addr_c = '0;
      wr_data_c = '0;
      case (state_q)
         ST_CLEAR: begin
            wr_en_c   = 1'b1;
            wr_addr_c = ptr_q;
         end
         ST_OUTPUT: begin
            rd_en_c   = !c_valid_q;
            rd_addr_c = ptr_q;
            wr_en_c   = c_valid_q && C_ready;
            wr_addr_c = ptr_q;
         end
         default: begin
            rd_en_c   = lane_rd_c;
            rd_addr_c = lane_addr_c;
            wr_en_c   = s1_valid_q;
            wr_addr_c = s1_addr_q;
            wr_data_c = acc_c;
         end
      endcase
   end

   coef_ram #(
      .DEPTH_P (DEPTH_P),
      .W       (COEF_W)
   ) u_ram (
      .clk_i     (clk_in),
      .rd_en_i   (rd_en_c),
      .rd_addr_i (rd_addr_c),
      .rd_data_o (rd_data_c),
      .wr_en_i   (wr_en_c),
      .wr_addr_i (wr_addr_c),
      .wr_data_i (wr_data_c)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= ST_CLEAR;
         ptr_q      <= '0;
         cnt_q      <= '0;
         b_ready_q  <= 1'b0;
         c_valid_q  <= 1'b0;
         idx_c_q    <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         lane_q     <= '0;
         beat_q     <= '0;
         base_q     <= '0;
         bad_q      <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s1_neg_q   <= 1'b0;
         s1_lane_q  <= '0;
         s1_hit_q   <= 1'b0;
         s1_fwd_q   <= '0;
      end else begin
         // Read stage -> write stage; capture a forward when this read races the current write.
         s1_valid_q <= lane_rd_c;
         if (lane_rd_c) begin
            s1_addr_q <= lane_addr_c;
            s1_neg_q  <= lane_neg_c;
            s1_lane_q <= lane_val_c;
            s1_hit_q  <= wr_en_c && (wr_addr_c == lane_addr_c);
            s1_fwd_q  <= wr_data_c;
         end

         // Lane sequencer: three lane slots per beat, ready re-opens for the third slot.
         if (accept_c) begin
            busy_q    <= 1'b1;
            lane_q    <= '0;
            beat_q    <= B_in;
            base_q    <= idx_B;
            bad_q     <= bad_c;
            cnt_q     <= cnt_q + CNT_W'(1);
            b_ready_q <= 1'b0;
            if (bad_c) begin
               err_q <= 1'b1;
            end
         end else if (busy_q) begin
            if (lane_q == 2'd2) begin
               busy_q <= 1'b0;
            end else begin
               lane_q <= lane_q + 2'd1;
            end
            if (lane_q == 2'd1 && cnt_q != BEATS_W) begin
               b_ready_q <= 1'b1;
            end
         end

         case (state_q)
            ST_CLEAR: begin
               ptr_q <= ptr_q + AW'(1);
               if (ptr_q == LAST_ADDR) begin
                  state_q   <= ST_ACCUM;
                  ptr_q     <= '0;
                  b_ready_q <= (BEATS_W != '0);
               end
            end
            ST_ACCUM: begin
               if (cnt_q == BEATS_W) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!busy_q && !s1_valid_q) begin
                  state_q <= ST_OUTPUT;
                  ptr_q   <= '0;
               end
            end
            ST_OUTPUT: begin
               if (!c_valid_q) begin
                  c_valid_q <= 1'b1;
                  idx_c_q   <= IDXC_W'(ptr_q);
               end else if (C_ready) begin
                  c_valid_q <= 1'b0;
                  if (ptr_q == LAST_ADDR) begin
                     state_q   <= ST_ACCUM;
                     ptr_q     <= '0;
                     cnt_q     <= '0;
                     b_ready_q <= 1'b1;
                  end else begin
                     ptr_q <= ptr_q + AW'(1);
                  end
               end
            end
            default: state_q <= ST_CLEAR;
         endcase
      end
   end

   assign B_ready = b_ready_q;
   assign C_valid = c_valid_q;
   assign idx_C   = idx_c_q;
   assign err_idx = err_q;
   // RAM read data is held while stalled because no read is issued during C_valid.
   assign C_out   = c_valid_q ? rd_data_c : '0;

endmodule

// File: tb/tb_pp_accumulator.sv
// Bench for pp_accumulator (DEPTH=8, BEATS=2) against a polynomial-level model.
module tb_pp_accumulator;
   import pp_acc_pkg::*;

   localparam int unsigned D    = 8;
   localparam int unsigned NB   = 2;
   localparam int unsigned MASK = 32'h3FFFF;

   logic                clk = 1'b0;
   logic                rst_in = 1'b0;
   logic                B_valid = 1'b0;
   logic                B_ready;
   logic [IDX_W-1:0]    idx_B = '0;
   logic [3*COEF_W-1:0] B_in = '0;
   logic                C_valid;
   logic                C_ready = 1'b0;
   logic [IDXC_W-1:0]   idx_C;
   logic [COEF_W-1:0]   C_out;
   logic                err_idx;

   int unsigned model [D];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pp_accumulator #(.DEPTH_P(D), .BEATS_P(NB)) dut (
      .clk_in  (clk),
      .rst_in  (rst_in),
      .B_valid (B_valid),
      .B_ready (B_ready),
      .idx_B   (idx_B),
      .B_in    (B_in),
      .C_valid (C_valid),
      .C_ready (C_ready),
      .idx_C   (idx_C),
      .C_out   (C_out),
      .err_idx (err_idx)
   );

   task automatic model_clear();
      for (int i = 0; i < D; i++) model[i] = 0;
   endtask

   // Product term x^p folds to -x^(p-D) beyond the ring degree.
   task automatic model_beat(input int unsigned idx, input int unsigned l0,
                             input int unsigned l1, input int unsigned l2);
      int unsigned lv [3];
      lv[0] = l0; lv[1] = l1; lv[2] = l2;
      if (idx > 2 * D - 3) return;
      for (int k = 0; k < 3; k++) begin
         int unsigned p;
         p = idx + k;
         if (p < D) model[p] = (model[p] + lv[k]) & MASK;
         else       model[p - D] = (model[p - D] - lv[k]) & MASK;
      end
   endtask

   task automatic send_beat(input int unsigned idx, input int unsigned l0,
                            input int unsigned l1, input int unsigned l2);
      int n;
      n = 0;
      idx_B   = IDX_W'(idx);
      B_in    = {COEF_W'(l2), COEF_W'(l1), COEF_W'(l0)};
      B_valid = 1'b1;
      while (!B_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (B_ready !== 1'b1) begin
         errors++;
         $display("FAIL beat_accept_timeout B_ready=%0b want 1", B_ready);
         B_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      B_valid = 1'b0;
      model_beat(idx, l0, l1, l2);
   endtask

   task automatic collect(input bit stall);
      int n;
      for (int i = 0; i < D; i++) begin
         n = 0;
         while (!C_valid && n < 100) begin
            @(posedge clk); #1; n++;
         end
         checks++;
         if (C_valid !== 1'b1) begin
            errors++;
            $display("FAIL c_valid_timeout coef %0d C_valid=%0b want 1", i, C_valid);
            return;
         end
         checks++;
         if (idx_C !== IDXC_W'(i)) begin
            errors++;
            $display("FAIL idx_order got %0d want %0d", idx_C, i);
         end
         checks++;
         if (C_out !== COEF_W'(model[i])) begin
            errors++;
            $display("FAIL coef[%0d] got 0x%05h want 0x%05h", i, C_out, model[i]);
         end
         if (stall) begin
            int ns;
            ns = int'($urandom_range(1, 3));
            for (int s = 0; s < ns; s++) begin
               @(posedge clk); #1;
               checks++;
               if (C_valid !== 1'b1 || idx_C !== IDXC_W'(i) || C_out !== COEF_W'(model[i])) begin
                  errors++;
                  $display("FAIL stall_hold coef %0d got v=%0b idx=%0d d=0x%05h want v=1 idx=%0d d=0x%05h",
                           i, C_valid, idx_C, C_out, i, model[i]);
               end
            end
         end
         C_ready = 1'b1;
         @(posedge clk); #1;
         C_ready = 1'b0;
         checks++;
         if (C_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_gap coef %0d C_valid=%0b want 0", i, C_valid);
         end
      end
      checks++;
      if (B_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_output B_ready=%0b want 1", B_ready);
      end
      model_clear();
   endtask

   task automatic do_reset();
      int n;
      rst_in = 1'b0;
      #1;
      checks++;
      if (B_ready !== 1'b0 || C_valid !== 1'b0 || idx_C !== '0 || C_out !== '0 || err_idx !== 1'b0) begin
         errors++;
         $display("FAIL reset_values got rdy=%0b v=%0b idx=%0d d=%0h err=%0b want all 0",
                  B_ready, C_valid, idx_C, C_out, err_idx);
      end
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_in = 1'b1;
      n = 0;
      while (!B_ready && n < 4 * D) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != D) begin
         errors++;
         $display("FAIL clear_length got %0d cycles want %0d", n, D);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (err_idx !== 1'b0) begin
         errors++;
         $display("FAIL err_after_reset got %0b want 0", err_idx);
      end
   endtask

   task automatic test_reset_mid_accum();
      send_beat($urandom_range(0, 2 * D - 3), $urandom & MASK, $urandom & MASK, $urandom & MASK);
      repeat (5) @(posedge clk);
      #1;
      do_reset();
      send_beat(0, 0, 0, 0);
      send_beat(0, 0, 0, 0);
      collect(1'b0);
   endtask

   task automatic test_single();
      send_beat(5, 1, 2, 3);
      checks++;
      if (B_ready !== 1'b0) begin errors++; $display("FAIL ready_t1 got %0b want 0", B_ready); end
      @(posedge clk); #1;
      checks++;
      if (B_ready !== 1'b0) begin errors++; $display("FAIL ready_t2 got %0b want 0", B_ready); end
      @(posedge clk); #1;
      checks++;
      if (B_ready !== 1'b1) begin errors++; $display("FAIL ready_t3 got %0b want 1", B_ready); end
      send_beat(0, 0, 0, 0);
      #1;
      checks++;
      if (B_ready !== 1'b0) begin errors++; $display("FAIL ready_after_last got %0b want 0", B_ready); end
      collect(1'b0);
   endtask

   task automatic test_back_to_back();
      send_beat(0, 1, 1, 1);
      send_beat(1, 1, 1, 1);
      collect(1'b0);
   endtask

   task automatic test_fold();
      send_beat(7, 3, 4, 5);
      send_beat(0, 0, 0, 0);
      collect(1'b0);
   endtask

   task automatic test_wrap_and_clear();
      send_beat(0, 32'h3FFFF, 0, 0);
      send_beat(0, 32'h3FFFF, 0, 0);
      collect(1'b0);
      send_beat(0, 0, 0, 0);
      send_beat(0, 0, 0, 0);
      collect(1'b0);
   endtask

   task automatic test_stall_err();
      send_beat(2 * D - 2, $urandom & MASK, $urandom & MASK, $urandom & MASK);
      checks++;
      if (err_idx !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", err_idx); end
      send_beat($urandom_range(0, 2 * D - 3), $urandom & MASK, $urandom & MASK, $urandom & MASK);
      collect(1'b1);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int b = 0; b < NB; b++)
            send_beat($urandom_range(0, 2 * D - 3), $urandom & MASK, $urandom & MASK, $urandom & MASK);
         collect(1'(r % 2));
      end
      checks++;
      if (err_idx !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err_idx); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fold();
      test_wrap_and_clear();
      test_reset_mid_accum();
      test_stall_err();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
